// File: rtl/fxp_div_pkg.sv
// ---------------------------------------------------------------------------
// fxp_div_pkg
// Shared definitions for the sequential fixed-point divider:
//   - state_t          : controller states (IDLE, CALC, DONE)
//   - sat_pos_lim()    : largest positive result magnitude for a width/signedness
//   - sat_neg_mag()    : magnitude of the most negative result (0 when unsigned)
// ---------------------------------------------------------------------------
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper clamp bound: 2^(w-1)-1 for two's complement, 2^w-1 for unsigned.
    function automatic longint unsigned sat_pos_lim(input int width, input int is_signed);
        if (is_signed != 32'sd0) begin
            return (64'd1 << (width - 1)) - 64'd1;
        end else begin
            return (64'd1 << width) - 64'd1;
        end
    endfunction

    // Magnitude of the lower clamp bound: 2^(w-1) for two's complement, 0 for unsigned.
    function automatic longint unsigned sat_neg_mag(input int width, input int is_signed);
        if (is_signed != 32'sd0) begin
            return 64'd1 << (width - 1);
        end else begin
            return 64'd0;
        end
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// ---------------------------------------------------------------------------
// fxp_div_step
// One combinational radix-2 restoring division iteration.
// Ports:
//   i_prem  [WIDTH:0]   current partial remainder
//   i_bit               next dividend bit (shifted in at the LSB)
//   i_dmag  [WIDTH-1:0] divisor magnitude
//   o_prem  [WIDTH:0]   updated partial remainder
//   o_qbit              quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module fxp_div_step
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dmag,
    output logic [WIDTH:0]   o_prem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // Shift, trial-subtract, restore on borrow.
    always_comb begin
        // The partial remainder is always below the divisor, so the shifted
        // value fits in WIDTH+1 bits and bit WIDTH+1 of the difference is a
        // clean borrow flag.
        w_shift = {i_prem, i_bit};
        w_diff  = w_shift - {2'b00, i_dmag};
        if (w_diff[WIDTH+1]) begin
            o_prem = w_shift[WIDTH:0];
            o_qbit = 1'b0;
        end else begin
            o_prem = w_diff[WIDTH:0];
            o_qbit = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// ---------------------------------------------------------------------------
// fxp_div_seq
// Sequential fixed-point divider, one restoring iteration per clock.
// quo = trunc((num * 2^FRAC) / den), saturated; rem follows the sign of num.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake (ready only while idle)
//   num, den [WIDTH]    operands, Q(WIDTH-FRAC).FRAC
//   out_valid/out_ready result handshake (valid only while holding a result)
//   quo, rem [WIDTH]    quotient and remainder
//   ovf                 quotient was clamped
//   dz                  divisor was zero
// ---------------------------------------------------------------------------
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FRAC   = 4,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             dz
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);
    localparam logic            IS_SIGNED = (SIGNED != 32'sd0);
    localparam logic [N-1:0]    L_POS_MAG = N'(sat_pos_lim(WIDTH, SIGNED));
    localparam logic [N-1:0]    L_NEG_MAG = N'(sat_neg_mag(WIDTH, SIGNED));
    localparam logic [CW-1:0]   CNT_LAST  = CW'(N - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dmag;
    logic             r_sign;
    logic             r_num_neg;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_ovf;
    logic             r_dz;

    logic             w_num_neg;
    logic             w_den_neg;
    logic [WIDTH-1:0] w_nmag;
    logic [WIDTH-1:0] w_dmag;
    logic [WIDTH-1:0] w_quo_dz;
    logic [WIDTH:0]   w_new_prem;
    logic             w_qbit;
    logic [N-1:0]     w_qmag;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_ovf_fix;

    fxp_div_step #(.WIDTH(WIDTH)) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[N-1]),
        .i_dmag (r_dmag),
        .o_prem (w_new_prem),
        .o_qbit (w_qbit)
    );

    // Operand sign/magnitude split and the divide-by-zero quotient.
    always_comb begin
        w_num_neg = IS_SIGNED & num[WIDTH-1];
        w_den_neg = IS_SIGNED & den[WIDTH-1];
        // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
        w_nmag    = w_num_neg ? (-num) : num;
        w_dmag    = w_den_neg ? (-den) : den;
        if (w_num_neg) begin
            w_quo_dz = L_NEG_MAG[WIDTH-1:0];
        end else begin
            w_quo_dz = L_POS_MAG[WIDTH-1:0];
        end
    end

    // Sign application and saturation of the final iteration's result.
    always_comb begin
        w_qmag    = {r_dvd[N-2:0], w_qbit};
        w_ovf_fix = 1'b0;
        w_quo_fix = {WIDTH{1'b0}};
        if (r_sign) begin
            if (w_qmag > L_NEG_MAG) begin
                w_ovf_fix = 1'b1;
                w_quo_fix = L_NEG_MAG[WIDTH-1:0];
            end else begin
                w_quo_fix = -w_qmag[WIDTH-1:0];
            end
        end else begin
            if (w_qmag > L_POS_MAG) begin
                w_ovf_fix = 1'b1;
                w_quo_fix = L_POS_MAG[WIDTH-1:0];
            end else begin
                w_quo_fix = w_qmag[WIDTH-1:0];
            end
        end
        if (r_num_neg) begin
            w_rem_fix = -w_new_prem[WIDTH-1:0];
        end else begin
            w_rem_fix = w_new_prem[WIDTH-1:0];
        end
    end

    // Controller, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_dvd       <= {N{1'b0}};
            r_prem      <= {(WIDTH+1){1'b0}};
            r_dmag      <= {WIDTH{1'b0}};
            r_sign      <= 1'b0;
            r_num_neg   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quo       <= {WIDTH{1'b0}};
            r_rem       <= {WIDTH{1'b0}};
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (den == {WIDTH{1'b0}}) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_quo       <= w_quo_dz;
                            r_rem       <= {WIDTH{1'b0}};
                            r_ovf       <= 1'b0;
                            r_dz        <= 1'b1;
                        end else begin
                            r_state   <= CALC;
                            r_dvd     <= N'(w_nmag) << FRAC;
                            r_prem    <= {(WIDTH+1){1'b0}};
                            r_dmag    <= w_dmag;
                            r_sign    <= w_num_neg ^ w_den_neg;
                            r_num_neg <= w_num_neg;
                            r_cnt     <= CNT_LAST;
                        end
                    end
                end
                CALC: begin
                    r_prem <= w_new_prem;
                    r_dvd  <= w_qmag;
                    if (r_cnt == {CW{1'b0}}) begin
                        // Final iteration: fix-up is captured on the same edge.
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quo       <= w_quo_fix;
                        r_rem       <= w_rem_fix;
                        r_ovf       <= w_ovf_fix;
                        r_dz        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quo       = r_quo;
    assign rem       = r_rem;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule
